// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS datapath.
// Drives pipe-register enable/flush and PC write enable, sequences halt,
// and counts stall cycles.
// Optional feature macro: HAZARD_FORWARD_EN (EX/MEM forwarding present;
// only load-use is treated as a data hazard). Undefined: any RAW stalls.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             idex_dREN,
    input  logic             idex_WEN,
    input  logic [4:0]       idex_wsel,
    input  logic             exmem_WEN,
    input  logic [4:0]       exmem_wsel,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ex_pcsrc,
    input  logic             wb_halt,
    output logic             pcEN,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_enable,
    output logic             idex_flush,
    output logic             exmem_enable,
    output logic             exmem_flush,
    output logic             memwb_enable,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic mem_busy;
    logic load_use;
    logic raw_haz;
    logic data_haz;

    // Hazard detection from the stage fields; MEM/WB never compared (write-before-read RF)
    always_comb begin
        mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
        load_use = idex_dREN & (idex_wsel != 5'd0) &
                   ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));
`ifdef HAZARD_FORWARD_EN
        raw_haz  = 1'b0;
`else
        raw_haz  = (idex_WEN & (idex_wsel != 5'd0) &
                    ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt))) |
                   (exmem_WEN & (exmem_wsel != 5'd0) &
                    ((exmem_wsel == ifid_rs) | (exmem_wsel == ifid_rt)));
`endif
        data_haz = load_use | raw_haz;
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-register pipe control; first matching rule wins
    always_comb begin
        next_state   = state;
        pcEN         = 1'b0;
        ifid_enable  = 1'b0;
        ifid_flush   = 1'b0;
        idex_enable  = 1'b0;
        idex_flush   = 1'b0;
        exmem_enable = 1'b0;
        exmem_flush  = 1'b0;
        memwb_enable = 1'b0;
        memwb_flush  = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    // full freeze: keep defaults
                end else if (ex_pcsrc) begin
                    pcEN         = 1'b1;
                    ifid_enable  = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_enable  = 1'b1;
                    idex_flush   = 1'b1;
                    exmem_enable = 1'b1;
                    memwb_enable = 1'b1;
                end else if (data_haz) begin
                    idex_enable  = 1'b1;
                    idex_flush   = 1'b1;
                    exmem_enable = 1'b1;
                    memwb_enable = 1'b1;
                end else if (!ihit) begin
                    ifid_enable  = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_enable  = 1'b1;
                    exmem_enable = 1'b1;
                    memwb_enable = 1'b1;
                end else begin
                    pcEN         = 1'b1;
                    ifid_enable  = 1'b1;
                    idex_enable  = 1'b1;
                    exmem_enable = 1'b1;
                    memwb_enable = 1'b1;
                end
                if (wb_halt && !mem_busy) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Registered halt flag mirrors entry into HALTED
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt <= 1'b0;
        end else begin
            halt <= (next_state == HALTED);
        end
    end

    // Saturating count of RUN cycles with the PC held
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && !pcEN && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: spec-level model checked every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK;
    logic             nRST;
    logic             ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_WEN;
    logic [4:0]       idex_wsel, exmem_wsel, ifid_rs, ifid_rt;
    logic             exmem_WEN, ex_pcsrc, wb_halt;
    logic             pcEN, ifid_enable, ifid_flush, idex_enable, idex_flush;
    logic             exmem_enable, exmem_flush, memwb_enable, memwb_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    bit m_halted = 1'b0;
    int m_cnt    = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_dREN(idex_dREN), .idex_WEN(idex_WEN), .idex_wsel(idex_wsel),
        .exmem_WEN(exmem_WEN), .exmem_wsel(exmem_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_pcsrc(ex_pcsrc), .wb_halt(wb_halt),
        .pcEN(pcEN), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
        .idex_enable(idex_enable), .idex_flush(idex_flush),
        .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
        .memwb_enable(memwb_enable), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does the ID instruction read a register still pending in EX or MEM?
    function automatic bit model_data_hazard();
        logic [4:0] dst [2];
        bit         wr  [2];
        dst[0] = idex_wsel;
        dst[1] = exmem_wsel;
`ifdef HAZARD_FORWARD_EN
        wr[0] = idex_dREN;
        wr[1] = 1'b0;
`else
        wr[0] = idex_dREN | idex_WEN;
        wr[1] = exmem_WEN;
`endif
        for (int i = 0; i < 2; i++) begin
            if (wr[i] && dst[i] != 5'd0 && (dst[i] == ifid_rs || dst[i] == ifid_rt))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_busy();
        return (exmem_dREN || exmem_dWEN) && !dhit;
    endfunction

    // {pcEN, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl}
    function automatic logic [8:0] model_ctrl(input bit halted);
        if (halted)              return 9'b0_00_00_00_00;
        if (model_busy())        return 9'b0_00_00_00_00;
        if (ex_pcsrc)            return 9'b1_11_11_10_10;
        if (model_data_hazard()) return 9'b0_00_11_10_10;
        if (!ihit)               return 9'b0_11_10_10_10;
        return 9'b1_10_10_10_10;
    endfunction

    // Per-cycle compare against the model, then advance the model across the next edge
    always @(negedge CLK) begin
        logic [8:0] exp_ctrl;
        logic [8:0] act_ctrl;
        if (!nRST) begin
            m_halted = 1'b0;
            m_cnt    = 0;
        end
        exp_ctrl = model_ctrl(m_halted);
        act_ctrl = {pcEN, ifid_enable, ifid_flush, idex_enable, idex_flush,
                    exmem_enable, exmem_flush, memwb_enable, memwb_flush};
        check("ctrl_vec", 32'(act_ctrl), 32'(exp_ctrl));
        check("halt", 32'(halt), 32'(m_halted));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (nRST && !m_halted) begin
            if (!exp_ctrl[8] && m_cnt < CNT_MAX) m_cnt++;
            if (wb_halt && !model_busy()) m_halted = 1'b1;
        end
    end

    task automatic defaults();
        ihit = 1'b1; dhit = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
        idex_dREN = 1'b0; idex_WEN = 1'b0; idex_wsel = 5'd0;
        exmem_WEN = 1'b0; exmem_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        ex_pcsrc = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        defaults();
        nRST = 1'b0;
        @(negedge CLK);
        #1;
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_pcEN", 32'(pcEN), 32'd1);
        nRST = 1'b1;
        step();
    endtask

    initial begin
        nRST = 1'b0;
        defaults();
        do_reset();

        // Load-use: one-cycle hold, then clean
        idex_dREN = 1'b1; idex_WEN = 1'b1; idex_wsel = 5'd5; ifid_rs = 5'd5; #1;
        check("lu_pcEN", 32'(pcEN), 32'd0);
        check("lu_ifid_en", 32'(ifid_enable), 32'd0);
        check("lu_idex_fl", 32'(idex_flush), 32'd1);
        step();
        idex_dREN = 1'b0; idex_WEN = 1'b0; idex_wsel = 5'd0; #1;
        check("lu_after_pcEN", 32'(pcEN), 32'd1);
        step();
        check("lu_cnt", 32'(stall_cnt), 32'd1);

        // Mem wait: 3 frozen cycles, resume on dhit
        do_reset();
        exmem_dREN = 1'b1; dhit = 1'b0; #1;
        check("mw_exmem_en", 32'(exmem_enable), 32'd0);
        check("mw_pcEN", 32'(pcEN), 32'd0);
        repeat (3) step();
        check("mw_cnt3", 32'(stall_cnt), 32'd3);
        dhit = 1'b1; #1;
        check("mw_resume_pcEN", 32'(pcEN), 32'd1);
        step();
        check("mw_cnt_final", 32'(stall_cnt), 32'd3);

        // Branch beats load-use
        do_reset();
        ex_pcsrc = 1'b1; idex_dREN = 1'b1; idex_wsel = 5'd7; ifid_rt = 5'd7; #1;
        check("br_pcEN", 32'(pcEN), 32'd1);
        check("br_ifid_fl", 32'(ifid_flush), 32'd1);
        check("br_idex_fl", 32'(idex_flush), 32'd1);
        check("br_ifid_en", 32'(ifid_enable), 32'd1);
        step();
        defaults();

        // Fetch miss for 2 cycles
        do_reset();
        ihit = 1'b0; #1;
        check("fm_ifid_fl", 32'(ifid_flush), 32'd1);
        check("fm_exmem_en", 32'(exmem_enable), 32'd1);
        step(); step();
        check("fm_cnt", 32'(stall_cnt), 32'd2);
        ex_pcsrc = 1'b1; #1;
        check("fm_redirect_pcEN", 32'(pcEN), 32'd1);
        step();
        defaults();

        // RAW on MEM-stage destination, and $0 never stalls
        do_reset();
        exmem_WEN = 1'b1; exmem_wsel = 5'd9; ifid_rt = 5'd9; #1;
`ifdef HAZARD_FORWARD_EN
        check("raw_mem_pcEN", 32'(pcEN), 32'd1);
`else
        check("raw_mem_pcEN", 32'(pcEN), 32'd0);
`endif
        step();
        exmem_wsel = 5'd0; ifid_rt = 5'd0; idex_WEN = 1'b1; idex_dREN = 1'b1;
        idex_wsel = 5'd0; ifid_rs = 5'd0; #1;
        check("wsel0_pcEN", 32'(pcEN), 32'd1);
        step();
        defaults();

        // Halt held off by a busy memory, then sticky until reset
        do_reset();
        wb_halt = 1'b1; exmem_dWEN = 1'b1; dhit = 1'b0;
        step(); step();
        check("h_busy_halt", 32'(halt), 32'd0);
        dhit = 1'b1; #1;
        check("h_dhit_halt", 32'(halt), 32'd0);
        step();
        check("h_set_halt", 32'(halt), 32'd1);
        defaults();
        repeat (3) step();
        check("h_sticky_halt", 32'(halt), 32'd1);
        check("h_pcEN", 32'(pcEN), 32'd0);
        check("h_cnt", 32'(stall_cnt), 32'd2);
        do_reset();
        check("h_post_rst_halt", 32'(halt), 32'd0);

        // Counter saturation
        ihit = 1'b0;
        repeat (CNT_MAX + 5) step();
        check("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        defaults();

        // Mixed sweep, model-checked every cycle
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                ihit       = ($urandom_range(0, 3) != 0);
                dhit       = $urandom_range(0, 1) != 0;
                exmem_dREN = ($urandom_range(0, 3) == 0);
                exmem_dWEN = ($urandom_range(0, 5) == 0);
                idex_dREN  = $urandom_range(0, 1) != 0;
                idex_WEN   = $urandom_range(0, 1) != 0;
                exmem_WEN  = $urandom_range(0, 1) != 0;
                idex_wsel  = 5'($urandom_range(0, 3));
                exmem_wsel = 5'($urandom_range(0, 3));
                ifid_rs    = 5'($urandom_range(0, 3));
                ifid_rt    = 5'($urandom_range(0, 3));
                ex_pcsrc   = ($urandom_range(0, 4) == 0);
                wb_halt    = ($urandom_range(0, 29) == 0);
                step();
            end
        end
        defaults();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS datapath: it drives the `enable` and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and the PC write enable. It detects the following conditions and sequences the processor halt:

- data-cache waits
- instruction-fetch misses
- taken branches and jumps
- load-use hazards

It sits beside the datapath, takes stage fields from the pipe register outputs, and returns per-register control each cycle.

## Interface
Parameters:
- `CNT_W`, 32, width of the stall-cycle performance counter.

Ports:
- `CLK`  in  1  system clock. Pipe registers latch on the active edge when enabled.
- `nRST`  in  1  reset. Asynchronous, active-low.
- `ihit`  in  1  instruction fetch completes this cycle.
- `dhit`  in  1  data access completes this cycle.
- `exmem_dREN`, `exmem_dWEN`  in  1 each  memory op held in the MEM stage.
- `idex_dREN`  in  1  load held in the EX stage.
- `idex_WEN`  in  1  EX-stage instruction writes the register file.
- `idex_wsel`  in  5  EX-stage destination register.
- `exmem_WEN`  in  1  MEM-stage instruction writes the register file.
- `exmem_wsel`  in  5  MEM-stage destination register.
- `ifid_rs`, `ifid_rt`  in  5 each  ID-stage source registers.
- `ex_pcsrc`  in  1  branch taken or jump resolved in EX.
- `wb_halt`  in  1  halt instruction present at the MEM/WB output.
- `pcEN`  out  1  PC may update.
- `ifid_enable`, `ifid_flush`  out  1 each.
- `idex_enable`, `idex_flush`  out  1 each.
- `exmem_enable`, `exmem_flush`  out  1 each.
- `memwb_enable`, `memwb_flush`  out  1 each.
- `halt`  out  1  registered; processor halted.
- `stall_cnt`  out  `CNT_W`  cycles in which `pcEN`=0 while in RUN.

## Operation
- The FSM has two states, RUN and HALTED.
- Outputs are combinational from the state and the inputs (Mealy). `halt` and `stall_cnt` are registered.
- A flush always comes with enable=1 on the same register, so the register loads a bubble (all zeros).
- In RUN, the first matching rule below applies:
  1. **Mem busy** (`(exmem_dREN|exmem_dWEN) & !dhit`): all enables, all flushes and `pcEN` are 0 (full freeze).
  2. **Redirect** (`ex_pcsrc`): `pcEN`=1, `ifid_flush`=1, `idex_flush`=1, all enables=1. Redirect outranks load-use because the ID instruction is squashed anyway.
  3. **Load-use** (`idex_dREN`, `idex_wsel`≠0, and `idex_wsel` equals `ifid_rs` or `ifid_rt`):
     - `pcEN`=0 and `ifid_enable`=0 (hold fetch and decode).
     - `idex_flush`=1 (bubble into EX).
     - `exmem_enable`=1, `memwb_enable`=1.
  4. **Fetch miss** (`!ihit`): `pcEN`=0, `ifid_flush`=1, downstream enables=1.
  5. **Normal:** `pcEN`=1, all enables=1, flushes=0.
- RUN→HALTED when `wb_halt` & !mem-busy. HALTED is sticky until `nRST`.
- In HALTED: all enables, flushes and `pcEN` are 0, and `halt`=1.
- The register file writes before it reads, so MEM/WB destinations are never compared.
- `stall_cnt` increments on every RUN cycle with `pcEN`=0 and saturates at all-ones. It does not count in HALTED.

## Timing
- Reset values:
  - state=RUN, `halt`=0, `stall_cnt`=0.
  - Combinational outputs follow the RUN rules.
- Every decision takes effect at the next active `CLK` edge (zero-cycle latency to the pipe registers).
- A load-use stall lasts exactly one cycle when memory is idle. The ID/EX bubble has `dREN`=0, so the next cycle is clean.
- Mem busy extends any stall. The frozen pipe resumes on the cycle `dhit`=1, and that cycle evaluates rules 2–5.
- Simultaneous `wb_halt` and mem busy: the freeze wins and HALTED is entered on the first non-busy cycle.
- Simultaneous `ex_pcsrc` and `!ihit`: `pcEN`=1 and the outstanding fetch is discarded.
- `nRST` low at any time immediately forces RUN and clears `halt` and `stall_cnt`.

## Configuration
- `HAZARD_FORWARD_EN` defined: the EX/MEM forwarding unit is present, and only load-use (rule 3) is detected as a data hazard.
- `HAZARD_FORWARD_EN` undefined: rule 3 also fires on any RAW hazard, using the same stall response:
  - `idex_WEN` & `idex_wsel`≠0 & `idex_wsel` ∈ {`ifid_rs`, `ifid_rt`}, or
  - `exmem_WEN` & `exmem_wsel`≠0 & `exmem_wsel` ∈ {`ifid_rs`, `ifid_rt`}.
- Without the macro, an add→dependent add sequence stalls 2 cycles.

## Test plan
- Load-use: `idex_dREN`=1, `idex_wsel`=5, `ifid_rs`=5, `ihit`=1 → one cycle with `pcEN`=0, `ifid_enable`=0, `idex_flush`=1; the next cycle is normal; `stall_cnt`=1.
- Mem wait: `exmem_dREN`=1, `dhit`=0 for 3 cycles, then `dhit`=1 → 3 cycles with all outputs 0, resume on the 4th; `stall_cnt`=3.
- Branch plus hazard: `ex_pcsrc`=1 with a load-use match → `pcEN`=1, `ifid_flush`=1, `idex_flush`=1, no hold.
- Fetch miss: `ihit`=0 for 2 cycles → `ifid_flush`=1 and `pcEN`=0 for both; `exmem_enable`=1.
- Halt: `wb_halt`=1 while `exmem_dWEN`=1 and `dhit`=0 → `halt` stays 0 until one cycle after `dhit`=1, then 1 and sticky. `nRST` pulse → `halt`=0, `stall_cnt`=0.
- Without `HAZARD_FORWARD_EN`: `exmem_WEN`=1, `exmem_wsel`=9, `ifid_rt`=9 → stall; with the macro defined → no stall. `wsel`=0 never stalls in either build.
